// File: rtl/serializer_buffered.sv
// Double-buffered parallel-to-serial converter.
// A one-word holding register decouples the upstream handshake from the shifter,
// so a queued word moves into the shifter on the same edge the previous word's
// last bit is consumed and the serial stream continues without an idle cycle.
module serializer_buffered #(
    parameter int   DATA_WIDTH = 8,
    parameter logic IDLE_BIT   = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    output logic                  DATA_READY,
    input  logic                  MSB_FIRST,
    input  logic                  SER_EN,
    input  logic                  ABORT,
    output logic                  SER_OUT,
    output logic                  SER_DONE,
    output logic                  BUSY
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

    // Stage 1: holding register
    logic [DATA_WIDTH-1:0] hold_reg_q, hold_reg_d;
    logic                  hold_msb_q, hold_msb_d;
    logic                  hold_vld_q, hold_vld_d;

    // Stage 2: shifter
    logic [DATA_WIDTH-1:0] sh_reg_q, sh_reg_d;
    logic                  sh_msb_q, sh_msb_d;
    logic                  sh_vld_q, sh_vld_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;

    logic accept;
    logic consume;
    logic last;
    logic load;

    // Handshake and shifter events; ABORT masks everything so a flush wins outright
    always_comb begin
        DATA_READY = ~hold_vld_q & ~ABORT;
        accept     = DATA_VALID & DATA_READY;
        consume    = SER_EN & sh_vld_q & ~ABORT;
        last       = consume & (bit_cnt_q == LAST_CNT);
        load       = (~sh_vld_q | last) & hold_vld_q & ~ABORT;
        SER_DONE   = last;
        BUSY       = hold_vld_q | sh_vld_q;
        SER_OUT    = sh_vld_q ? (sh_msb_q ? sh_reg_q[DATA_WIDTH-1] : sh_reg_q[0]) : IDLE_BIT;
    end

    // Next-state for both stages; bit order of the word in flight is fixed by sh_msb
    always_comb begin
        hold_reg_d = hold_reg_q;
        hold_msb_d = hold_msb_q;
        hold_vld_d = hold_vld_q;
        sh_reg_d   = sh_reg_q;
        sh_msb_d   = sh_msb_q;
        sh_vld_d   = sh_vld_q;
        bit_cnt_d  = bit_cnt_q;

        if (ABORT) begin
            hold_vld_d = 1'b0;
            sh_vld_d   = 1'b0;
            bit_cnt_d  = '0;
        end else begin
            if (consume && !last) begin
                sh_reg_d  = sh_msb_q ? (sh_reg_q << 1) : (sh_reg_q >> 1);
                bit_cnt_d = bit_cnt_q + CW'(1);
            end

            if (load) begin
                sh_reg_d   = hold_reg_q;
                sh_msb_d   = hold_msb_q;
                sh_vld_d   = 1'b1;
                bit_cnt_d  = '0;
                hold_vld_d = 1'b0;
            end else if (last) begin
                sh_vld_d  = 1'b0;
                bit_cnt_d = '0;
            end

            // Accept only happens with the holding register empty, so it never collides with load
            if (accept) begin
                hold_reg_d = P_DATA;
                hold_msb_d = MSB_FIRST;
                hold_vld_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hold_reg_q <= '0;
            hold_msb_q <= 1'b0;
            hold_vld_q <= 1'b0;
            sh_reg_q   <= '0;
            sh_msb_q   <= 1'b0;
            sh_vld_q   <= 1'b0;
            bit_cnt_q  <= '0;
        end else begin
            hold_reg_q <= hold_reg_d;
            hold_msb_q <= hold_msb_d;
            hold_vld_q <= hold_vld_d;
            sh_reg_q   <= sh_reg_d;
            sh_msb_q   <= sh_msb_d;
            sh_vld_q   <= sh_vld_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

endmodule

// File: tb/tb_serializer_buffered.sv
// Bench for serializer_buffered: three lanes (widths 8, 2, 32; lane 1 idles high)
// checked every cycle against a word-level reference model, plus directed sequences.
module tb_serializer_buffered;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  pd0;
    logic [1:0]  pd1;
    logic [31:0] pd2;
    logic [2:0]  dv, dr, msb, sen, ab, so, sd, bz;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serializer_buffered #(.DATA_WIDTH(8), .IDLE_BIT(1'b0)) u_w8 (
        .CLK(clk), .RST(rst_n), .P_DATA(pd0), .DATA_VALID(dv[0]), .DATA_READY(dr[0]),
        .MSB_FIRST(msb[0]), .SER_EN(sen[0]), .ABORT(ab[0]), .SER_OUT(so[0]),
        .SER_DONE(sd[0]), .BUSY(bz[0]));

    serializer_buffered #(.DATA_WIDTH(2), .IDLE_BIT(1'b1)) u_w2 (
        .CLK(clk), .RST(rst_n), .P_DATA(pd1), .DATA_VALID(dv[1]), .DATA_READY(dr[1]),
        .MSB_FIRST(msb[1]), .SER_EN(sen[1]), .ABORT(ab[1]), .SER_OUT(so[1]),
        .SER_DONE(sd[1]), .BUSY(bz[1]));

    serializer_buffered #(.DATA_WIDTH(32), .IDLE_BIT(1'b0)) u_w32 (
        .CLK(clk), .RST(rst_n), .P_DATA(pd2), .DATA_VALID(dv[2]), .DATA_READY(dr[2]),
        .MSB_FIRST(msb[2]), .SER_EN(sen[2]), .ABORT(ab[2]), .SER_OUT(so[2]),
        .SER_DONE(sd[2]), .BUSY(bz[2]));

    // Reference model: a queued word and the word being sent, with a count of bits already sent
    logic        m_hold_vld[3], m_sh_vld[3], m_hold_msb[3], m_sh_msb[3];
    logic [31:0] m_hold_word[3], m_sh_word[3];
    int          m_pos[3];
    logic        n_hold_vld[3], n_sh_vld[3], n_hold_msb[3], n_sh_msb[3];
    logic [31:0] n_hold_word[3], n_sh_word[3];
    int          n_pos[3];

    // Values seen at the last sampling point
    logic [2:0] obs_so, obs_sd, obs_dr, obs_bz;

    function automatic int wid(input int i);
        return (i == 0) ? 8 : (i == 1) ? 2 : 32;
    endfunction

    function automatic logic idle_lvl(input int i);
        return (i == 1) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic [31:0] get_pd(input int i);
        return (i == 0) ? {24'd0, pd0} : (i == 1) ? {30'd0, pd1} : pd2;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_hold_vld[i] = 1'b0; m_sh_vld[i] = 1'b0;
            m_hold_msb[i] = 1'b0; m_sh_msb[i] = 1'b0;
            m_hold_word[i] = '0;  m_sh_word[i] = '0;
            m_pos[i] = 0;
        end
    endtask

    task automatic clr_inputs();
        pd0 = '0; pd1 = '0; pd2 = '0;
        dv = '0; msb = '0; sen = '0; ab = '0;
    endtask

    // One clock cycle: check outputs at the falling edge, advance the model at the rising edge
    task automatic step();
        int    w, idx;
        logic  ready, cons, lastb, exp_out;
        @(negedge clk);
        obs_so = so; obs_sd = sd; obs_dr = dr; obs_bz = bz;
        for (int i = 0; i < 3; i++) begin
            w       = wid(i);
            ready   = !m_hold_vld[i] && !ab[i];
            cons    = sen[i] && m_sh_vld[i] && !ab[i];
            lastb   = cons && (m_pos[i] == w - 1);
            idx     = m_sh_msb[i] ? (w - 1 - m_pos[i]) : m_pos[i];
            exp_out = m_sh_vld[i] ? m_sh_word[i][idx] : idle_lvl(i);
            check($sformatf("L%0d ser_out", i),    {31'd0, so[i]}, {31'd0, exp_out});
            check($sformatf("L%0d ser_done", i),   {31'd0, sd[i]}, {31'd0, lastb});
            check($sformatf("L%0d data_ready", i), {31'd0, dr[i]}, {31'd0, ready});
            check($sformatf("L%0d busy", i),       {31'd0, bz[i]}, {31'd0, m_hold_vld[i] | m_sh_vld[i]});

            n_hold_vld[i] = m_hold_vld[i]; n_sh_vld[i] = m_sh_vld[i];
            n_hold_msb[i] = m_hold_msb[i]; n_sh_msb[i] = m_sh_msb[i];
            n_hold_word[i] = m_hold_word[i]; n_sh_word[i] = m_sh_word[i];
            n_pos[i] = m_pos[i];
            if (ab[i]) begin
                n_hold_vld[i] = 1'b0;
                n_sh_vld[i]   = 1'b0;
                n_pos[i]      = 0;
            end else begin
                if (cons) begin
                    n_pos[i] = m_pos[i] + 1;
                    if (n_pos[i] == w) begin
                        n_sh_vld[i] = 1'b0;
                        n_pos[i]    = 0;
                    end
                end
                if (!n_sh_vld[i] && m_hold_vld[i]) begin
                    n_sh_word[i]  = m_hold_word[i];
                    n_sh_msb[i]   = m_hold_msb[i];
                    n_sh_vld[i]   = 1'b1;
                    n_pos[i]      = 0;
                    n_hold_vld[i] = 1'b0;
                end
                if (dv[i] && ready) begin
                    n_hold_word[i] = get_pd(i);
                    n_hold_msb[i]  = msb[i];
                    n_hold_vld[i]  = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            m_hold_vld[i] = n_hold_vld[i]; m_sh_vld[i] = n_sh_vld[i];
            m_hold_msb[i] = n_hold_msb[i]; m_sh_msb[i] = n_sh_msb[i];
            m_hold_word[i] = n_hold_word[i]; m_sh_word[i] = n_sh_word[i];
            m_pos[i] = n_pos[i];
        end
    endtask

    // Lane 0: send one word with SER_EN high, gather 8 bits in send order
    task automatic send8(input logic [7:0] word, input logic msb_first,
                         output logic [7:0] bits, output int done_cnt, output int done_pos);
        clr_inputs();
        pd0 = word; dv[0] = 1'b1; msb[0] = msb_first; sen[0] = 1'b1;
        step();                       // accept
        dv[0] = 1'b0;
        step();                       // hold -> shifter
        done_cnt = 0; done_pos = -1; bits = '0;
        for (int k = 0; k < 8; k++) begin
            step();
            bits[k] = obs_so[0];
            if (obs_sd[0]) begin done_cnt++; done_pos = k; end
        end
        step();                       // back to idle
    endtask

    initial begin
        logic [7:0] bits, rev;
        int dc, dp, d1, d2, consumes;

        clr_inputs();
        model_reset();
        rst_n = 1'b0;
        #22;
        check("reset ser_out", {29'd0, so}, 32'd2);
        check("reset ready",   {29'd0, dr}, 32'd7);
        check("reset busy",    {29'd0, bz}, 32'd0);
        check("reset done",    {29'd0, sd}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // LSB first
        send8(8'hA5, 1'b0, bits, dc, dp);
        check("T2 bits", {24'd0, bits}, 32'hA5);
        check("T2 done_cnt", dc, 1);
        check("T2 done_pos", dp, 7);
        $display("[TB] T2 lsb-first A5 bits=%02h", bits);

        // MSB first
        send8(8'hA5, 1'b1, bits, dc, dp);
        for (int k = 0; k < 8; k++) rev[k] = bits[7 - k];
        check("T3 bits A5", {24'd0, rev}, 32'hA5);
        check("T3 done_pos", dp, 7);
        send8(8'h01, 1'b1, bits, dc, dp);
        check("T3 bits 01", {24'd0, bits}, 32'h80);
        $display("[TB] T3 msb-first done");

        // Back-to-back stream
        clr_inputs();
        sen[0] = 1'b1; pd0 = 8'h3C; dv[0] = 1'b1;
        step();
        pd0 = 8'hC3;
        for (int k = 0; k < 6; k++) begin
            step();
            if (obs_dr[0]) break;
        end
        dv[0] = 1'b0;
        d1 = -1; d2 = -1;
        for (int k = 0; k < 24; k++) begin
            step();
            if (obs_sd[0]) begin
                if (d1 < 0) d1 = k; else d2 = k;
            end
        end
        check("T4 done gap", d2 - d1, 8);
        $display("[TB] T4 stream done pulses at %0d and %0d", d1, d2);

        // Stall with SER_EN toggling
        clr_inputs();
        pd0 = 8'hF0; dv[0] = 1'b1; sen[0] = 1'b1;
        step();
        dv[0] = 1'b0;
        dc = 0; consumes = 0;
        for (int k = 0; k < 24; k++) begin
            sen[0] = k[0];
            step();
            if (obs_sd[0]) begin
                dc++;
                check("T5 consumes before done", consumes, 7);
            end
            if (sen[0] && obs_bz[0] && !obs_sd[0] && obs_so[0] !== 1'bx && dc == 0 && k > 0) consumes++;
        end
        check("T5 done_cnt", dc, 1);
        $display("[TB] T5 stall done");

        // Abort with hold full and a word offered
        clr_inputs();
        pd0 = 8'hFF; dv[0] = 1'b1; sen[0] = 1'b1;
        step();
        dv[0] = 1'b0;
        step();
        for (int k = 0; k < 3; k++) step();
        pd0 = 8'h55; dv[0] = 1'b1;
        step();                       // 55 lands in hold
        pd0 = 8'hAA; ab[0] = 1'b1;
        step();
        check("T6 ready during abort", {31'd0, obs_dr[0]}, 32'd0);
        check("T6 done during abort",  {31'd0, obs_sd[0]}, 32'd0);
        ab[0] = 1'b0; dv[0] = 1'b0;
        step();
        check("T6 busy after", {31'd0, obs_bz[0]}, 32'd0);
        check("T6 ser_out after", {31'd0, obs_so[0]}, 32'd0);
        $display("[TB] T6 abort done");

        // Full-rate stream on all widths
        clr_inputs();
        for (int k = 0; k < 150; k++) begin
            dv = 3'b111; sen = 3'b111; msb = 3'($urandom);
            pd0 = 8'($urandom); pd1 = 2'($urandom); pd2 = $urandom;
            step();
        end

        // Randomised traffic on all lanes, with an asynchronous reset in the middle
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 3; i++) begin
                dv[i]  = ($urandom_range(0, 9) < 7);
                sen[i] = ($urandom_range(0, 3) != 0);
                ab[i]  = ($urandom_range(0, 39) == 0);
                msb[i] = 1'($urandom);
            end
            pd0 = 8'($urandom); pd1 = 2'($urandom); pd2 = $urandom;
            step();
            if (k == 1500) begin
                dv = '0; ab = '0; sen = 3'b111;
                #2 rst_n = 1'b0;
                #1;
                check("T1 ser_out", {29'd0, so}, 32'd2);
                check("T1 ready",   {29'd0, dr}, 32'd7);
                check("T1 busy",    {29'd0, bz}, 32'd0);
                check("T1 done",    {29'd0, sd}, 32'd0);
                model_reset();
                @(negedge clk); rst_n = 1'b1;
                @(posedge clk); #1;
                $display("[TB] T1 async reset mid-traffic");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
